adc_scan_sequencer: RTL and testbench

- Time-multiplexes the single 8-bit PWM ramp ADC (PWM DAC, comparator and sweep logic) across NUM_CH analog inputs behind an external analog mux.
- Per enabled channel it selects the mux, waits for the input to settle, restarts the sweep and collects AVG samples.
- Stores the averaged result in a per-channel register bank and streams it out.
- Sits between the sweep block and the MIDI/control logic that consumes sampled values.

---
 rtl/adc_pkg.sv | 15 +
 rtl/adc_chan_pick.sv | 25 ++
 rtl/adc_scan_sequencer.sv | 237 +++++++++++++++++++++++
 tb/tb_adc_scan_sequencer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// Shared definitions for the ADC scan sequencer and the sweep block it drives.
package adc_pkg;

  localparam int ADC_WIDTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SELECT  = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_CONVERT = 3'd3,
    ST_STORE   = 3'd4,
    ST_NEXT    = 3'd5
  } adc_state_e;

endpackage

// File: rtl/adc_chan_pick.sv
// Combinational channel finder: lowest set bit of a mask and the next set bit above a given index.
module adc_chan_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] mask,
  input  logic [W-1:0] cur,
  output logic [W-1:0] next_idx,
  output logic         found,
  output logic [W-1:0] lowest_idx
);

  // Scan from the top down so the last hit is the lowest qualifying bit.
  always_comb begin
    next_idx   = '0;
    found      = 1'b0;
    lowest_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      lowest_idx = mask[i] ? W'(i) : lowest_idx;
      next_idx   = (mask[i] && (i > int'(cur))) ? W'(i) : next_idx;
      found      = (mask[i] && (i > int'(cur))) ? 1'b1 : found;
    end
  end

endmodule

// File: rtl/adc_scan_sequencer.sv
// Multiplexes one PWM ramp ADC across NUM_CH mux inputs, averaging AVG samples per channel
// into a readable result bank and streaming each result out as it completes.
module adc_scan_sequencer
  import adc_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int WIDTH          = ADC_WIDTH,
  parameter int SETTLE_CYCLES  = 1024,
  parameter int AVG_LOG2       = 2,
  parameter int TIMEOUT_CYCLES = 4194304,
  localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              continuous,
  input  logic [NUM_CH-1:0] ch_mask,
  output logic              busy,
  output logic [CH_W-1:0]   mux_sel,
  output logic              sweep_reset,
  output logic              sweep_enable,
  input  logic              sweep_drdy,
  input  logic [WIDTH-1:0]  sweep_data,
  output logic              result_valid,
  output logic [CH_W-1:0]   result_chan,
  output logic [WIDTH-1:0]  result_data,
  output logic              timeout_err,
  input  logic [CH_W-1:0]   rd_chan,
  output logic [WIDTH-1:0]  rd_data
);

  localparam int ACC_W   = WIDTH + AVG_LOG2;
  localparam int NS_W    = AVG_LOG2 + 1;
  localparam int CNT_MAX = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LOAD    = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [NS_W-1:0]  NS_FULL     = NS_W'(32'd1 << AVG_LOG2);

  adc_state_e        state_q, state_d;
  logic [CH_W-1:0]   chan_q, chan_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic [CH_W-1:0]   mux_sel_q, mux_sel_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [NS_W-1:0]   nsamp_q, nsamp_d;
  logic              drdy_q;
  logic              busy_q, busy_d;
  logic              sweep_reset_q, sweep_reset_d;
  logic              sweep_enable_q, sweep_enable_d;
  logic              result_valid_q, result_valid_d;
  logic [CH_W-1:0]   result_chan_q, result_chan_d;
  logic [WIDTH-1:0]  result_data_q, result_data_d;
  logic              timeout_err_q, timeout_err_d;
  logic [WIDTH-1:0]  bank_q [NUM_CH];
  logic [WIDTH-1:0]  bank_d [NUM_CH];

  logic              edge_s;
  logic [WIDTH-1:0]  sample_s;
  logic [WIDTH-1:0]  avg_s;
  logic [CH_W-1:0]   cur_next_s, cur_lowest_s;
  logic              cur_found_s;
  logic [CH_W-1:0]   in_next_s, in_lowest_s;
  logic              in_found_s;
  logic              unused_pick_s;

  adc_chan_pick #(.N(NUM_CH), .W(CH_W)) u_pick_cur (
    .mask       (mask_q),
    .cur        (chan_q),
    .next_idx   (cur_next_s),
    .found      (cur_found_s),
    .lowest_idx (cur_lowest_s)
  );

  adc_chan_pick #(.N(NUM_CH), .W(CH_W)) u_pick_in (
    .mask       (ch_mask),
    .cur        (chan_q),
    .next_idx   (in_next_s),
    .found      (in_found_s),
    .lowest_idx (in_lowest_s)
  );

  assign unused_pick_s = ^{in_next_s, in_found_s, cur_lowest_s};

  // A missing sample (timeout) is replaced by full scale so it is obvious in the average.
  assign edge_s   = sweep_drdy & ~drdy_q;
  assign sample_s = edge_s ? sweep_data : {WIDTH{1'b1}};

  // Next-state and next-output computation for the scan sequencer.
  always_comb begin
    state_d        = state_q;
    chan_d         = chan_q;
    mask_d         = mask_q;
    cnt_d          = cnt_q;
    acc_d          = acc_q;
    nsamp_d        = nsamp_q;
    result_valid_d = 1'b0;
    result_chan_d  = result_chan_q;
    result_data_d  = result_data_q;
    timeout_err_d  = timeout_err_q;
    bank_d         = bank_q;
    avg_s          = '0;

    case (state_q)
      ST_IDLE: begin
        if (start && (ch_mask != '0)) begin
          mask_d        = ch_mask;
          chan_d        = in_lowest_s;
          timeout_err_d = 1'b0;
          state_d       = ST_SELECT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SELECT: begin
        cnt_d   = SETTLE_LOAD;
        acc_d   = '0;
        nsamp_d = '0;
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt_q == '0) begin
          cnt_d   = TMO_LOAD;
          state_d = ST_CONVERT;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_CONVERT: begin
        if (edge_s || (cnt_q == '0)) begin
          acc_d         = acc_q + ACC_W'(sample_s);
          nsamp_d       = nsamp_q + NS_W'(1);
          timeout_err_d = timeout_err_q | ~edge_s;
          if (nsamp_d == NS_FULL) begin
            avg_s          = WIDTH'(acc_d >> AVG_LOG2);
            result_valid_d = 1'b1;
            result_chan_d  = chan_q;
            result_data_d  = avg_s;
            bank_d[chan_q] = avg_s;
            state_d        = ST_STORE;
          end else begin
            cnt_d = TMO_LOAD;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_STORE: begin
        state_d = ST_NEXT;
      end
      ST_NEXT: begin
        if (cur_found_s) begin
          chan_d  = cur_next_s;
          state_d = ST_SELECT;
        end else if (continuous) begin
          // Wrap point: the only place a new channel mask is taken mid-run.
          mask_d = ch_mask;
          if (ch_mask != '0) begin
            chan_d  = in_lowest_s;
            state_d = ST_SELECT;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d         = (state_d != ST_IDLE);
    sweep_enable_d = (state_d == ST_CONVERT);
    sweep_reset_d  = (state_d == ST_SELECT);
    mux_sel_d      = (state_d == ST_SELECT) ? chan_d : mux_sel_q;
  end

  // State, datapath and registered outputs; the sweep is held in reset while we are.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      chan_q         <= '0;
      mask_q         <= '0;
      mux_sel_q      <= '0;
      cnt_q          <= '0;
      acc_q          <= '0;
      nsamp_q        <= '0;
      drdy_q         <= 1'b0;
      busy_q         <= 1'b0;
      sweep_reset_q  <= 1'b1;
      sweep_enable_q <= 1'b0;
      result_valid_q <= 1'b0;
      result_chan_q  <= '0;
      result_data_q  <= '0;
      timeout_err_q  <= 1'b0;
      bank_q         <= '{default: '0};
    end else begin
      state_q        <= state_d;
      chan_q         <= chan_d;
      mask_q         <= mask_d;
      mux_sel_q      <= mux_sel_d;
      cnt_q          <= cnt_d;
      acc_q          <= acc_d;
      nsamp_q        <= nsamp_d;
      drdy_q         <= sweep_drdy;
      busy_q         <= busy_d;
      sweep_reset_q  <= sweep_reset_d;
      sweep_enable_q <= sweep_enable_d;
      result_valid_q <= result_valid_d;
      result_chan_q  <= result_chan_d;
      result_data_q  <= result_data_d;
      timeout_err_q  <= timeout_err_d;
      bank_q         <= bank_d;
    end
  end

  // Combinational readback; out-of-range selects read as zero.
  always_comb begin
    if (int'(rd_chan) < NUM_CH) begin
      rd_data = bank_q[rd_chan];
    end else begin
      rd_data = '0;
    end
  end

  assign busy         = busy_q;
  assign mux_sel      = mux_sel_q;
  assign sweep_reset  = sweep_reset_q;
  assign sweep_enable = sweep_enable_q;
  assign result_valid = result_valid_q;
  assign result_chan  = result_chan_q;
  assign result_data  = result_data_q;
  assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Self-checking bench for adc_scan_sequencer with a behavioural sweep model and result scoreboard.
module tb_adc_scan_sequencer;

  localparam int NUM_CH = 4;
  localparam int WIDTH  = 8;
  localparam int SETTLE = 8;
  localparam int AVG    = 2;
  localparam int TMO    = 100;
  localparam int CH_W   = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              continuous;
  logic [NUM_CH-1:0] ch_mask;
  logic              busy;
  logic [CH_W-1:0]   mux_sel;
  logic              sweep_reset;
  logic              sweep_enable;
  logic              sweep_drdy;
  logic [WIDTH-1:0]  sweep_data;
  logic              result_valid;
  logic [CH_W-1:0]   result_chan;
  logic [WIDTH-1:0]  result_data;
  logic              timeout_err;
  logic [CH_W-1:0]   rd_chan;
  logic [WIDTH-1:0]  rd_data;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int mode;          // 0 random data, 1 fixed table, 2 stale drdy, 3 silent
  int nsent, sum, dly;
  int res_chan_q[$];
  int res_data_q[$];
  int res_cyc_q[$];
  int mdl_avg_q[$];
  int sel_q[$];
  int sreset_cnt = 0;
  int st_cyc;

  adc_scan_sequencer #(
    .NUM_CH(NUM_CH), .WIDTH(WIDTH), .SETTLE_CYCLES(SETTLE),
    .AVG_LOG2(AVG), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(rst_n), .start(start), .continuous(continuous),
    .ch_mask(ch_mask), .busy(busy), .mux_sel(mux_sel),
    .sweep_reset(sweep_reset), .sweep_enable(sweep_enable),
    .sweep_drdy(sweep_drdy), .sweep_data(sweep_data),
    .result_valid(result_valid), .result_chan(result_chan),
    .result_data(result_data), .timeout_err(timeout_err),
    .rd_chan(rd_chan), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Result / mux-select monitor
  always @(negedge clk) begin
    if (rst_n && result_valid) begin
      res_chan_q.push_back(int'(result_chan));
      res_data_q.push_back(int'(result_data));
      res_cyc_q.push_back(cyc);
    end
    if (rst_n && sweep_reset) begin
      sel_q.push_back(int'(mux_sel));
      sreset_cnt++;
    end
  end

  // Sweep block model: each new conversion is a fresh rising edge of drdy while enabled
  always @(negedge clk) begin
    if (!rst_n || sweep_reset) begin
      nsent = 0; sum = 0; dly = $urandom_range(1, 20); sweep_drdy = 1'b0;
    end else if (mode == 3) begin
      sweep_drdy = 1'b0;
    end else if (!sweep_enable) begin
      if (mode == 2 && nsent == 0) begin
        sweep_drdy = 1'b1; sweep_data = 8'hEE;
      end
    end else if (nsent < 4) begin
      if (dly > 0) dly--;
      else if (sweep_drdy) sweep_drdy = 1'b0;
      else begin
        if (mode == 1) sweep_data = (mux_sel == 2'd0) ? 8'(10 + nsent) : 8'd200;
        else sweep_data = 8'($urandom_range(0, 255));
        sweep_drdy = 1'b1;
        sum += int'(sweep_data);
        nsent++;
        dly = $urandom_range(1, 20);
        if (nsent == 4) mdl_avg_q.push_back(sum / 4);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic mask_order(input logic [3:0] m, output int q[$]);
    q.delete();
    for (int i = 0; i < NUM_CH; i++) if (m[i]) q.push_back(i);
  endtask

  task automatic clear_q;
    res_chan_q.delete(); res_data_q.delete(); res_cyc_q.delete();
    mdl_avg_q.delete(); sel_q.delete();
  endtask

  task automatic pulse_start(input logic [3:0] m, input logic c);
    @(negedge clk); ch_mask = m; continuous = c; start = 1'b1;
    @(negedge clk); start = 1'b0; st_cyc = cyc;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy && n < budget) begin @(negedge clk); n++; end
    check(tag, 32'(busy), 32'd0);
  endtask

  task automatic wait_enable(input string tag);
    int n = 0;
    while (!sweep_enable && n < 200) begin @(negedge clk); n++; end
    check(tag, 32'(sweep_enable), 32'd1);
  endtask

  task automatic read_bank(input string tag, input int ch, input int exp);
    rd_chan = CH_W'(ch); #1;
    check(tag, 32'(rd_data), 32'(exp));
  endtask

  task automatic check_results(input string tag, input int order[$]);
    check({tag, "_count"}, 32'(res_chan_q.size()), 32'(order.size()));
    check({tag, "_mdl_count"}, 32'(mdl_avg_q.size()), 32'(order.size()));
    for (int i = 0; i < order.size(); i++) begin
      check($sformatf("%s_chan%0d", tag, i), 32'(qget(res_chan_q, i)), 32'(order[i]));
      check($sformatf("%s_data%0d", tag, i), 32'(qget(res_data_q, i)), 32'(qget(mdl_avg_q, i)));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int order[$];
    logic [3:0] m;
    int n;
    rst_n = 1'b0; start = 1'b0; continuous = 1'b0; ch_mask = '0; rd_chan = '0;
    sweep_drdy = 1'b0; sweep_data = '0; mode = 1;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sweep_reset", 32'(sweep_reset), 32'd1);
    check("rst_sweep_enable", 32'(sweep_enable), 32'd0);
    check("rst_result_valid", 32'(result_valid), 32'd0);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);
    check("rst_mux_sel", 32'(mux_sel), 32'd0);
    check("rst_result_data", 32'(result_data), 32'd0);
    for (int i = 0; i < NUM_CH; i++) read_bank($sformatf("rst_bank%0d", i), i, 0);
    @(negedge clk); rst_n = 1'b1; #1;
    check("rel_sweep_reset_hold", 32'(sweep_reset), 32'd1);
    @(negedge clk);
    check("rel_sweep_reset_drop", 32'(sweep_reset), 32'd0);

    // Directed scan: ch0 gets 10..13, ch2 gets 200s
    mode = 1; clear_q();
    pulse_start(4'b0101, 1'b0);
    wait_idle("t1_idle", 2000);
    check("t1_count", 32'(res_chan_q.size()), 32'd2);
    check("t1_chan0", 32'(qget(res_chan_q, 0)), 32'd0);
    check("t1_data0", 32'(qget(res_data_q, 0)), 32'd11);
    check("t1_chan1", 32'(qget(res_chan_q, 1)), 32'd2);
    check("t1_data1", 32'(qget(res_data_q, 1)), 32'd200);
    check("t1_sel_count", 32'(sel_q.size()), 32'd2);
    check("t1_sel0", 32'(qget(sel_q, 0)), 32'd0);
    check("t1_sel1", 32'(qget(sel_q, 1)), 32'd2);
    check("t1_hold_data", 32'(result_data), 32'd200);
    read_bank("t1_bank0", 0, 11);
    read_bank("t1_bank1", 1, 0);
    read_bank("t1_bank2", 2, 200);

    // Start with an empty mask is ignored
    n = sreset_cnt;
    pulse_start(4'b0000, 1'b0);
    repeat (5) @(negedge clk);
    check("t2_busy", 32'(busy), 32'd0);
    check("t2_no_sweep_reset", 32'(sreset_cnt), 32'(n));

    // Start while busy is ignored
    mode = 0; clear_q();
    pulse_start(4'b0010, 1'b0);
    repeat (20) @(negedge clk);
    check("t3_busy", 32'(busy), 32'd1);
    ch_mask = 4'b1111; start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_idle("t3_idle", 2000);
    mask_order(4'b0010, order);
    check_results("t3", order);

    // Random masks with random sample data
    for (int k = 0; k < 4; k++) begin
      m = 4'($urandom_range(1, 15));
      clear_q();
      pulse_start(m, 1'b0);
      wait_idle($sformatf("rnd%0d_idle", k), 3000);
      mask_order(m, order);
      check_results($sformatf("rnd%0d", k), order);
      for (int i = 0; i < order.size(); i++)
        read_bank($sformatf("rnd%0d_bank%0d", k, i), order[i], qget(mdl_avg_q, i));
    end

    // Stale drdy and edges during settle are never counted
    mode = 2; clear_q();
    pulse_start(4'b0001, 1'b0);
    wait_idle("stale_idle", 2000);
    mask_order(4'b0001, order);
    check_results("stale", order);
    check("stale_timeout_err", 32'(timeout_err), 32'd0);

    // Silent sweep: every sample times out and is replaced by full scale
    mode = 3; clear_q();
    pulse_start(4'b0100, 1'b0);
    wait_idle("tmo_idle", 1000);
    check("tmo_count", 32'(res_chan_q.size()), 32'd1);
    check("tmo_chan", 32'(qget(res_chan_q, 0)), 32'd2);
    check("tmo_data", 32'(qget(res_data_q, 0)), 32'hFF);
    check("tmo_latency", 32'(qget(res_cyc_q, 0) - st_cyc), 32'(1 + SETTLE + 4 * TMO));
    check("tmo_err", 32'(timeout_err), 32'd1);
    read_bank("tmo_bank2", 2, 255);
    mode = 1; clear_q();
    pulse_start(4'b0001, 1'b0);
    check("tmo_err_cleared", 32'(timeout_err), 32'd0);
    wait_idle("tmo2_idle", 2000);
    check("tmo2_data", 32'(qget(res_data_q, 0)), 32'd11);

    // Continuous: mask change takes effect at the wrap, dropping continuous ends after the scan
    mode = 0; clear_q();
    pulse_start(4'b1000, 1'b1);
    wait_enable("cont_en");
    ch_mask = 4'b0011;
    n = 0;
    while (res_chan_q.size() < 2 && n < 2000) begin @(negedge clk); n++; end
    check("cont_two_results", 32'(res_chan_q.size() >= 2), 32'd1);
    n = 0;
    while (!(sweep_enable && mux_sel == 2'd1) && n < 500) begin @(negedge clk); n++; end
    check("cont_ch1_convert", 32'(sweep_enable && mux_sel == 2'd1), 32'd1);
    continuous = 1'b0;
    wait_idle("cont_idle", 2000);
    order = '{3, 0, 1};
    check_results("cont", order);

    // Reset mid-conversion aborts and clears the bank
    mode = 0; clear_q();
    pulse_start(4'b1111, 1'b0);
    wait_enable("arst_en");
    @(negedge clk); rst_n = 1'b0; #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_sweep_reset", 32'(sweep_reset), 32'd1);
    check("arst_sweep_enable", 32'(sweep_enable), 32'd0);
    for (int i = 0; i < NUM_CH; i++) read_bank($sformatf("arst_bank%0d", i), i, 0);
    @(negedge clk);
    check("arst_sweep_reset_held", 32'(sweep_reset), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);
    mode = 1; clear_q();
    pulse_start(4'b0001, 1'b0);
    wait_idle("post_rst_idle", 2000);
    check("post_rst_count", 32'(res_chan_q.size()), 32'd1);
    check("post_rst_data", 32'(qget(res_data_q, 0)), 32'd11);
    read_bank("post_rst_bank0", 0, 11);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
